// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder stage. One full-adder slice plus a carry
//                flip-flop consumes the operands LSB-first, one bit per clock,
//                and the WIDTH-bit sum and carry-out are then offered
//                downstream over a valid/ready handshake.
//
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous, active-high reset
//                in_valid   - A/B/Cin valid
//                in_ready   - block can accept operands (state IDLE)
//                A, B       - WIDTH-bit operands
//                Cin        - carry-in
//                sub        - subtract select (only with SERIAL_ADDER_SUB_EN)
//                out_valid  - S/Cout valid (state DONE)
//                out_ready  - consumer accepts result
//                S, Cout    - sum and final carry-out
//                busy       - high while bits are being processed (state RUN)
//
//  Options     : SERIAL_ADDER_SUB_EN - adds the sub port; sub=1 computes
//                A - B - Cin, with Cout=1 meaning "no borrow".
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy
);

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic             w_sum_bit;
    logic             w_carry_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtraction through the same slice:
    // A + ~B + ~Cin = A - B - Cin + 2^WIDTH, so the carry-out is "no borrow".
    assign w_b_load   = sub ? ~B   : B;
    assign w_cin_load = sub ? ~Cin : Cin;
`else
    assign w_b_load   = B;
    assign w_cin_load = Cin;
`endif

    assign w_accept     = in_valid && (r_state == c_st_idle);
    assign w_last       = (r_cnt == c_last_cnt);

    // The single full-adder slice.
    assign w_sum_bit    = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
    assign w_carry_next = (r_sh_a[0] & r_sh_b[0]) |
                          (r_sh_a[0] & r_carry)   |
                          (r_sh_b[0] & r_carry);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            c_st_idle: if (in_valid)  w_next_state = c_st_run;
            c_st_run:  if (w_last)    w_next_state = c_st_done;
            c_st_done: if (out_ready) w_next_state = c_st_idle;
            default:                  w_next_state = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (r_state == c_st_idle);
        busy      = (r_state == c_st_run);
        out_valid = (r_state == c_st_done);
    end

    // ------------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sh_a  <= A;
            r_sh_b  <= w_b_load;
            r_carry <= w_cin_load;
            r_s     <= '0;
            r_cnt   <= '0;
        end else if (r_state == c_st_run) begin
            r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
            r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
            r_s     <= {w_sum_bit, r_s[WIDTH-1:1]};
            r_carry <= w_carry_next;
            if (w_last) begin
                // Counter is left at its terminal value so it never wraps.
                r_cout <= w_carry_next;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. A WIDTH=8 instance
//                takes directed vectors (including reset abort and
//                backpressure); a WIDTH=4 instance takes all 512 {A,B,Cin}
//                combinations back-to-back. A transaction-level model
//                predicts handshake flags and results every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       iv8 = 1'b0, or8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ir8, ov8, co8, bz8;
    logic [7:0] s8;

    // WIDTH=4 instance
    logic       iv4 = 1'b0, or4 = 1'b1, cin4 = 1'b0, sub4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ir4, ov4, co4, bz4;
    logic [3:0] s4;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .Cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .S(s8), .Cout(co8), .busy(bz8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4),
        .A(a4), .B(b4), .Cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub4),
`endif
        .out_valid(ov4), .out_ready(or4), .S(s4), .Cout(co4), .busy(bz4)
    );

    int n_checks = 0;
    int n_errors = 0;
    int hs4      = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: plain integer add, or subtract offset by 2^w so
    // the top bit reads as "no borrow".
    function automatic int ref_sum(int w, int a, int b, int c, logic s);
        if (s) return a + (1 << w) - b - c;
        return a + b + c;
    endfunction

    // ------------------------------------------------------------------------
    // Transaction model: phase 0 = waiting for operands, 1 = computing for
    // `left` more edges, 2 = result offered. Result is computed at acceptance.
    // ------------------------------------------------------------------------
    int         m8_ph, m8_left, m4_ph, m4_left;
    logic [8:0] m8_res;
    logic [4:0] m4_res;
    logic [7:0] m8_s;
    logic [3:0] m4_s;
    logic       m8_c, m4_c;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_ph <= 0; m8_left <= 0; m8_res <= '0; m8_s <= '0; m8_c <= 1'b0;
        end else begin
            case (m8_ph)
                0: if (iv8) begin
                    m8_res  <= 9'(ref_sum(8, int'(a8), int'(b8), int'(cin8), sub8));
                    m8_left <= 8;
                    m8_ph   <= 1;
                end
                1: if (m8_left == 1) begin
                    m8_ph <= 2;
                    {m8_c, m8_s} <= m8_res;
                end else begin
                    m8_left <= m8_left - 1;
                end
                default: if (or8) m8_ph <= 0;
            endcase
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4_ph <= 0; m4_left <= 0; m4_res <= '0; m4_s <= '0; m4_c <= 1'b0;
        end else begin
            case (m4_ph)
                0: if (iv4) begin
                    m4_res  <= 5'(ref_sum(4, int'(a4), int'(b4), int'(cin4), sub4));
                    m4_left <= 4;
                    m4_ph   <= 1;
                end
                1: if (m4_left == 1) begin
                    m4_ph <= 2;
                    {m4_c, m4_s} <= m4_res;
                end else begin
                    m4_left <= m4_left - 1;
                end
                default: if (or4) m4_ph <= 0;
            endcase
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("in_ready8",  ir8, m8_ph == 0);
        chk("busy8",      bz8, m8_ph == 1);
        chk("out_valid8", ov8, m8_ph == 2);
        if (m8_ph != 1) begin
            chk("S8",    s8,  m8_s);
            chk("Cout8", co8, m8_c);
        end
        chk("in_ready4",  ir4, m4_ph == 0);
        chk("busy4",      bz4, m4_ph == 1);
        chk("out_valid4", ov4, m4_ph == 2);
        if (m4_ph != 1) begin
            chk("S4",    s4,  m4_s);
            chk("Cout4", co4, m4_c);
        end
        if (ov4 && or4) hs4++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation on the 8-bit instance and wait for out_valid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic s, input string nm);
        int cyc;
        a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        cyc = 0;
        while (!ov8 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({nm, "_latency"}, cyc, 8);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", ir8, 1'b1);
        chk("reset_S",        s8,  8'h00);
        chk("reset_Cout",     co8, 1'b0);

        // Plain addition
        run8(8'h5A, 8'h33, 1'b0, 1'b0, "add_5A_33");
        chk("add_5A_33_S",    s8,  8'h8D);
        chk("add_5A_33_Cout", co8, 1'b0);
        tick();

        // Carry ripples through every bit
        run8(8'hFF, 8'h01, 1'b1, 1'b0, "add_FF_01_1");
        chk("add_FF_01_1_S",    s8,  8'h01);
        chk("add_FF_01_1_Cout", co8, 1'b1);
        tick();

        // Backpressure: result held, new operands refused
        or8 = 1'b0;
        run8(8'h12, 8'h34, 1'b0, 1'b0, "bp");
        for (int k = 0; k < 5; k++) begin
            iv8 = ~iv8;
            a8  = 8'(k * 37 + 3);
            b8  = 8'(k * 11 + 9);
            tick();
            chk("bp_in_ready", ir8, 1'b0);
            chk("bp_S",        s8,  8'h46);
            chk("bp_Cout",     co8, 1'b0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        chk("bp_release_in_ready", ir8, 1'b1);
        chk("bp_release_S",        s8,  8'h46);

        // Reset during the third RUN cycle aborts the operation
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        chk("pre_abort_busy", bz8, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("abort_S",         s8,  8'h00);
        chk("abort_Cout",      co8, 1'b0);
        chk("abort_out_valid", ov8, 1'b0);
        chk("abort_busy",      bz8, 1'b0);
        chk("abort_in_ready",  ir8, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        run8(8'h80, 8'h80, 1'b0, 1'b0, "after_abort");
        chk("after_abort_S",    s8,  8'h00);
        chk("after_abort_Cout", co8, 1'b1);
        tick();

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h10, 8'h01, 1'b0, 1'b1, "sub_10_01");
        chk("sub_10_01_S",    s8,  8'h0F);
        chk("sub_10_01_Cout", co8, 1'b1);
        tick();
        run8(8'h00, 8'h01, 1'b0, 1'b1, "sub_00_01");
        chk("sub_00_01_S",    s8,  8'hFF);
        chk("sub_00_01_Cout", co8, 1'b0);
        tick();
        sub8 = 1'b0;
`endif

        // WIDTH=4: all combinations back-to-back, one every 6 cycles
        hs4 = 0;
        or4 = 1'b1;
        iv4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            {a4, b4, cin4} = 9'(i);
            repeat (6) tick();
        end
        iv4 = 1'b0;
        repeat (4) tick();
        chk("exhaustive4_results", hs4, 512);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder stage built around a single one-bit full-adder slice plus a carry flip-flop.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Streams the operands LSB-first through the slice, one bit per clock, then presents the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits directly downstream of the operand source and upstream of the result consumer.
- Trades WIDTH cycles of latency for a one-bit datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands A/B/Cin valid.
- in_ready  out  1  block can accept operands.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in.
- out_valid  out  1  S/Cout valid.
- out_ready  in  1  consumer accepts result.
- S  out  WIDTH  sum.
- Cout  out  1  final carry-out.
- busy  out  1  high in RUN.
- sub  in  1  subtract select; present only with SERIAL_ADDER_SUB_EN.

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values: state=IDLE; S=0; Cout=0; out_valid=0; busy=0; in_ready=1; internal shift registers, carry and counter all 0.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - busy = (state==RUN).
- IDLE:
  - On the clk edge where in_valid & in_ready: latch A->shA, B->shB, Cin->carry; clear cnt and the S shift register; go to RUN.
  - A/B/Cin are ignored on every other cycle.
- RUN, each edge:
  - sum_bit = shA[0]^shB[0]^carry.
  - carry <= majority(shA[0], shB[0], carry).
  - S shifts right with sum_bit inserted at the MSB; shA and shB shift right; cnt increments.
  - On the edge where cnt == WIDTH-1: take the last bit, load Cout with the final carry, go to DONE.
- Latency: if the acceptance edge is edge 0, out_valid goes high after edge WIDTH. Example: WIDTH=8 gives out_valid from cycle 8.
- DONE:
  - S and Cout are held stable while out_ready=0 (unbounded backpressure).
  - On the edge with out_ready=1, go to IDLE. S and Cout keep their value until the next acceptance.
- No input acceptance in RUN or DONE. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: {Cout,S} == A + B + Cin, modulo 2^(WIDTH+1). Overflow is reported only through Cout.
- cnt width is $clog2(WIDTH). cnt never wraps within one operation.
- rst asserted mid-RUN or mid-DONE: immediate abort. All outputs and state return to reset values and the in-flight result is lost.
- in_valid held high continuously: a new operation is accepted on the first IDLE cycle after each DONE handshake.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Port sub exists and is latched at acceptance.
  - sub=1: shB loads ~B and carry loads ~Cin, so {Cout,S} = A - B - Cin.
  - Cout=1 means no borrow; Cout=0 means borrow.
  - sub=0 behaves exactly as the plain adder.
- Not defined: port sub is absent and the block is add-only.

Test Plan:
- Reset: assert rst for 1 cycle at the 3rd RUN cycle -> S=0, Cout=0, out_valid=0, busy=0, in_ready=1 the same cycle. A new operation then runs normally.
- WIDTH=8, A=8'h5A, B=8'h33, Cin=0 -> S=8'h8D, Cout=0. out_valid rises exactly 8 cycles after the acceptance edge; busy is high for those 8 cycles.
- WIDTH=8, A=8'hFF, B=8'h01, Cin=1 -> S=8'h01, Cout=1 (carry ripples the full width).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> S/Cout unchanged, in_ready=0, no new capture. Raise out_ready -> IDLE and in_ready=1 on the next cycle.
- WIDTH=4, exhaustive 512 {A,B,Cin} combinations with in_valid and out_ready held high back-to-back -> every result matches A+B+Cin; issue interval is 6 cycles.
- With SERIAL_ADDER_SUB_EN, WIDTH=8:
  - sub=1, A=8'h10, B=8'h01, Cin=0 -> S=8'h0F, Cout=1.
  - sub=1, A=8'h00, B=8'h01, Cin=0 -> S=8'hFF, Cout=0.
